// File: rtl/icache_nb_ctrl.sv
// Non-blocking direct-mapped instruction cache controller: tag/valid arrays, tag-indexed
// miss table with squash, cross-port miss merging and a skipping next-line prefetcher.
module icache_nb_ctrl #(
    parameter int unsigned N_PORTS        = 2,
    parameter int unsigned ADDR_BITS      = 16,
    parameter int unsigned NUM_SETS       = 32,
    parameter int unsigned MEM_TAG_BITS   = 4,
    parameter int unsigned PREFETCH_DEPTH = 2,
    localparam int unsigned IDX_W         = $clog2(NUM_SETS),
    localparam int unsigned TAG_W         = ADDR_BITS - IDX_W - 3
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [N_PORTS-1:0]                  proc2Icache_en,
    input  logic [N_PORTS-1:0][ADDR_BITS-1:0]   proc2Icache_addr,
    input  logic                                flush,
    input  logic [MEM_TAG_BITS-1:0]             Imem2proc_transaction_tag,
    input  logic [MEM_TAG_BITS-1:0]             Imem2proc_data_tag,
    output logic [1:0]                          proc2Imem_command,
    output logic [ADDR_BITS-1:0]                proc2Imem_addr,
    output logic [N_PORTS-1:0]                  Icache_valid_out,
    output logic [N_PORTS-1:0][IDX_W-1:0]       rd_idx,
    output logic [IDX_W-1:0]                    wr_idx,
    output logic                                data_write_enable,
    output logic                                mshr_full,
    output logic [31:0]                         miss_count
);

    localparam int unsigned LINE_W = ADDR_BITS - 3;
    localparam int unsigned N_MSHR = 1 << MEM_TAG_BITS;
    localparam int unsigned CNT_W  = $clog2(PREFETCH_DEPTH + 2);
    localparam logic [1:0]  MEM_NONE = 2'd0;
    localparam logic [1:0]  MEM_LOAD = 2'd1;

    logic [NUM_SETS-1:0]     r_valid;
    logic [TAG_W-1:0]        r_tag [NUM_SETS];
    logic [N_MSHR-1:0]       r_mshr_valid;
    logic [N_MSHR-1:0]       r_mshr_squash;
    logic [LINE_W-1:0]       r_mshr_line [N_MSHR];
    logic [LINE_W-1:0]       r_pf_line;
    logic [CNT_W-1:0]        r_pf_cnt;
    logic [31:0]             r_miss_count;

    logic [LINE_W-1:0]       w_line [N_PORTS];
    logic [N_PORTS-1:0]      w_hit;
    logic [N_PORTS-1:0]      w_pend;
    logic [N_PORTS-1:0]      w_need;
    logic [N_PORTS-1:0]      w_unused_off;
    logic                    w_dem_valid;
    logic [LINE_W-1:0]       w_dem_line;
    logic [IDX_W-1:0]        w_pf_idx;
    logic                    w_pf_cached;
    logic                    w_pf_pend;
    logic                    w_pf_ok;
    logic                    w_pf_skip;
    logic                    w_full;
    logic                    w_issue;
    logic                    w_accept;
    logic [LINE_W-1:0]       w_req_line;
    logic                    w_resp;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        assign w_line[p]       = proc2Icache_addr[p][ADDR_BITS-1:3];
        assign rd_idx[p]       = w_line[p][IDX_W-1:0];
        assign w_hit[p]        = proc2Icache_en[p] & r_valid[w_line[p][IDX_W-1:0]]
                                 & (r_tag[w_line[p][IDX_W-1:0]] == w_line[p][LINE_W-1:IDX_W]);
        assign w_unused_off[p] = |proc2Icache_addr[p][2:0];
    end

    always_comb begin
        w_pend    = '0;
        w_pf_pend = 1'b0;
        // Entry 0 is never allocated, so scanning it is harmless.
        for (int t = 0; t < N_MSHR; t++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (r_mshr_valid[t] && (r_mshr_line[t] == w_line[p])) w_pend[p] = 1'b1;
            end
            if (r_mshr_valid[t] && (r_mshr_line[t] == r_pf_line)) w_pf_pend = 1'b1;
        end
        w_need = proc2Icache_en & ~w_hit & ~w_pend;

        // Descending scan so the lowest-numbered missing port wins.
        w_dem_valid = 1'b0;
        w_dem_line  = '0;
        for (int p = N_PORTS - 1; p >= 0; p--) begin
            if (w_need[p]) begin
                w_dem_valid = 1'b1;
                w_dem_line  = w_line[p];
            end
        end

        w_pf_idx    = r_pf_line[IDX_W-1:0];
        w_pf_cached = r_valid[w_pf_idx] & (r_tag[w_pf_idx] == r_pf_line[LINE_W-1:IDX_W]);
        w_pf_ok     = (r_pf_cnt != '0) & ~w_pf_cached & ~w_pf_pend;
        w_pf_skip   = (r_pf_cnt != '0) & (w_pf_cached | w_pf_pend);
        w_full      = &r_mshr_valid[N_MSHR-1:1];
        w_issue     = reset_n & (w_dem_valid | w_pf_ok) & ~w_full & ~flush;
        w_req_line  = w_dem_valid ? w_dem_line : r_pf_line;
        w_accept    = w_issue & (Imem2proc_transaction_tag != '0);
        w_resp      = (Imem2proc_data_tag != '0) & r_mshr_valid[Imem2proc_data_tag];

        proc2Imem_command = w_issue ? MEM_LOAD : MEM_NONE;
        proc2Imem_addr    = w_issue ? {w_req_line, 3'b000} : '0;
        data_write_enable = w_resp & ~r_mshr_squash[Imem2proc_data_tag];
        wr_idx            = r_mshr_line[Imem2proc_data_tag][IDX_W-1:0];
    end

    assign Icache_valid_out = w_hit;
    assign mshr_full        = w_full;
    assign miss_count       = r_miss_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid       <= '0;
            r_mshr_valid  <= '0;
            r_mshr_squash <= '0;
            r_pf_line     <= '0;
            r_pf_cnt      <= '0;
            r_miss_count  <= '0;
            for (int i = 0; i < NUM_SETS; i++) r_tag[i] <= '0;
            for (int t = 0; t < N_MSHR; t++) r_mshr_line[t] <= '0;
        end else begin
            if (w_resp) begin
                r_mshr_valid[Imem2proc_data_tag] <= 1'b0;
                if (!r_mshr_squash[Imem2proc_data_tag]) begin
                    r_valid[wr_idx] <= 1'b1;
                    r_tag[wr_idx]   <= r_mshr_line[Imem2proc_data_tag][LINE_W-1:IDX_W];
                end
            end
            // Later assignment lets a same-tag allocation override the response clear.
            if (w_accept) begin
                r_mshr_valid[Imem2proc_transaction_tag]  <= 1'b1;
                r_mshr_squash[Imem2proc_transaction_tag] <= 1'b0;
                r_mshr_line[Imem2proc_transaction_tag]   <= w_req_line;
            end
            if (w_accept && w_dem_valid) begin
                r_pf_line <= w_dem_line + LINE_W'(1);
                r_pf_cnt  <= CNT_W'(PREFETCH_DEPTH);
                if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
            end else if (w_accept || w_pf_skip) begin
                r_pf_line <= r_pf_line + LINE_W'(1);
                r_pf_cnt  <= r_pf_cnt - CNT_W'(1);
            end
            if (flush) begin
                r_valid       <= '0;
                r_mshr_squash <= r_mshr_squash | r_mshr_valid;
                r_pf_cnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_icache_nb_ctrl.sv
// Randomized and directed bench for icache_nb_ctrl against a line-level reference model;
// the bench plays instruction memory, handing out free tags and returning outstanding ones.
module tb_icache_nb_ctrl;

    localparam int NS = 32;
    localparam int NM = 16;
    localparam int PD = 2;
    localparam int unsigned LINES = 8192;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [1:0]       en;
    logic [1:0][15:0] addr;
    logic             flush;
    logic [3:0]       ttag;
    logic [3:0]       dtag;
    logic [1:0]       cmd;
    logic [15:0]      mem_addr;
    logic [1:0]       vo;
    logic [1:0][4:0]  ridx;
    logic [4:0]       widx;
    logic             we;
    logic             full;
    logic [31:0]      mcount;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: cache lines by set, outstanding misses by tag, prefetch cursor.
    bit          m_valid [NS];
    int unsigned m_tag   [NS];
    bit          mv      [NM];
    bit          msq     [NM];
    int unsigned mline   [NM];
    int unsigned pf_line;
    int unsigned pf_cnt;
    longint unsigned miss_cnt;

    icache_nb_ctrl dut (
        .clock                     (clock),
        .reset_n                   (reset_n),
        .proc2Icache_en            (en),
        .proc2Icache_addr          (addr),
        .flush                     (flush),
        .Imem2proc_transaction_tag (ttag),
        .Imem2proc_data_tag        (dtag),
        .proc2Imem_command         (cmd),
        .proc2Imem_addr            (mem_addr),
        .Icache_valid_out          (vo),
        .rd_idx                    (ridx),
        .wr_idx                    (widx),
        .data_write_enable         (we),
        .mshr_full                 (full),
        .miss_count                (mcount)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic bit cached(input int unsigned line);
        return m_valid[line % NS] && (m_tag[line % NS] == line / NS);
    endfunction

    function automatic bit pending(input int unsigned line);
        for (int t = 1; t < NM; t++) if (mv[t] && mline[t] == line) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_full();
        for (int t = 1; t < NM; t++) if (!mv[t]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        for (int t = 0; t < NM; t++) begin
            mv[t]  = 1'b0;
            msq[t] = 1'b0;
        end
        pf_line  = 0;
        pf_cnt   = 0;
        miss_cnt = 0;
    endtask

    // One clock: drive at the falling edge, compare just after, then advance the model.
    task automatic step(input logic [1:0] e, input logic [15:0] a0, input logic [15:0] a1,
                        input logic f, input logic [3:0] tt, input logic [3:0] dt);
        int          dem;
        bit          pfok;
        bit          iss;
        bit          resp;
        bit          fill;
        bit [1:0]    exp_vo;
        int unsigned lines [2];
        int unsigned rl;
        @(negedge clock);
        en = e; addr[0] = a0; addr[1] = a1; flush = f; ttag = tt; dtag = dt;
        #1;
        lines[0] = 32'(a0) / 8;
        lines[1] = 32'(a1) / 8;
        dem      = -1;
        exp_vo   = 2'b00;
        for (int p = 0; p < 2; p++) begin
            if (e[p] && cached(lines[p])) exp_vo[p] = 1'b1;
            else if (e[p] && !pending(lines[p]) && dem < 0) dem = p;
        end
        pfok = (pf_cnt > 0) && !cached(pf_line) && !pending(pf_line);
        iss  = (dem >= 0 || pfok) && !model_full() && !f;
        rl   = (dem >= 0) ? lines[dem] : pf_line;
        resp = (dt != 0) && mv[dt];
        fill = resp && !msq[dt];
        check_eq("command", 32'(cmd), iss ? 32'd1 : 32'd0);
        check_eq("mem_addr", 32'(mem_addr), iss ? rl * 8 : 32'd0);
        check_eq("valid_out", 32'(vo), 32'(exp_vo));
        check_eq("rd_idx0", 32'(ridx[0]), lines[0] % NS);
        check_eq("rd_idx1", 32'(ridx[1]), lines[1] % NS);
        check_eq("mshr_full", 32'(full), 32'(model_full()));
        check_eq("write_en", 32'(we), 32'(fill));
        if (fill) check_eq("wr_idx", 32'(widx), mline[dt] % NS);
        check_eq("miss_count", mcount, 32'(miss_cnt));

        if (resp) begin
            if (!msq[dt]) begin
                m_valid[mline[dt] % NS] = 1'b1;
                m_tag[mline[dt] % NS]   = mline[dt] / NS;
            end
            mv[dt] = 1'b0;
        end
        if (iss && tt != 0) begin
            mv[tt]    = 1'b1;
            msq[tt]   = 1'b0;
            mline[tt] = rl;
            if (dem >= 0) begin
                pf_line = (rl + 1) % LINES;
                pf_cnt  = PD;
                if (miss_cnt < 64'hFFFF_FFFF) miss_cnt++;
            end else begin
                pf_line = (pf_line + 1) % LINES;
                pf_cnt--;
            end
        end else if (pf_cnt > 0 && !pfok) begin
            pf_line = (pf_line + 1) % LINES;
            pf_cnt--;
        end
        if (f) begin
            for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
            for (int t = 0; t < NM; t++) if (mv[t]) msq[t] = 1'b1;
            pf_cnt = 0;
        end
    endtask

    task automatic idle_inputs();
        en = 2'b00; addr = '0; flush = 1'b0; ttag = 4'd0; dtag = 4'd0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_command"}, 32'(cmd), 32'd0);
        check_eq({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({pfx, "_valid_out"}, 32'(vo), 32'd0);
        check_eq({pfx, "_write_en"}, 32'(we), 32'd0);
        check_eq({pfx, "_mshr_full"}, 32'(full), 32'd0);
        check_eq({pfx, "_miss_count"}, mcount, 32'd0);
    endtask

    function automatic logic [15:0] rand_addr();
        int unsigned line;
        line = ($urandom_range(0, 15) == 0) ? $urandom_range(LINES - 2, LINES - 1)
                                            : $urandom_range(0, 127);
        return 16'(line * 8 + $urandom_range(0, 7));
    endfunction

    function automatic logic [3:0] pick_tag(input bit want_valid);
        int s;
        s = $urandom_range(1, NM - 1);
        for (int k = 0; k < NM - 1; k++) begin
            int t;
            t = 1 + ((s - 1 + k) % (NM - 1));
            if (mv[t] == want_valid) return 4'(t);
        end
        return 4'd0;
    endfunction

    initial begin
        logic [15:0] a0;
        logic [15:0] a1;
        logic [3:0]  dt;
        logic [3:0]  tt;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check_reset_outputs("reset");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // Cold miss, fill, then hit.
        step(2'b01, 16'h0100, 16'h0000, 1'b0, 4'd3, 4'd0);
        check_eq("t1_cmd", 32'(cmd), 32'd1);
        check_eq("t1_addr", 32'(mem_addr), 32'h0100);
        check_eq("t1_vo", 32'(vo), 32'd0);
        step(2'b00, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0);
        step(2'b00, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0);
        step(2'b00, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd3);
        check_eq("t1_we", 32'(we), 32'd1);
        check_eq("t1_widx", 32'(widx), 32'd0);
        step(2'b01, 16'h0100, 16'h0000, 1'b0, 4'd0, 4'd0);
        check_eq("t1_hit", 32'(vo), 32'd1);
        check_eq("t1_miss", mcount, 32'd1);

        // Flush squashes an in-flight miss and invalidates the cached line.
        step(2'b01, 16'h0500, 16'h0000, 1'b0, 4'd5, 4'd0);
        check_eq("fl_addr", 32'(mem_addr), 32'h0500);
        step(2'b00, 16'h0000, 16'h0000, 1'b1, 4'd0, 4'd0);
        check_eq("fl_cmd", 32'(cmd), 32'd0);
        step(2'b00, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd5);
        check_eq("fl_we", 32'(we), 32'd0);
        step(2'b01, 16'h0100, 16'h0000, 1'b0, 4'd0, 4'd0);
        check_eq("fl_vo", 32'(vo), 32'd0);
        check_eq("fl_reissue", 32'(mem_addr), 32'h0100);

        // Demand restarts a two-line prefetch, then the port goes quiet.
        step(2'b01, 16'h0200, 16'h0000, 1'b0, 4'd4, 4'd0);
        step(2'b00, 16'h0000, 16'h0000, 1'b0, 4'd6, 4'd0);
        check_eq("pf_first", 32'(mem_addr), 32'h0208);
        step(2'b00, 16'h0000, 16'h0000, 1'b0, 4'd9, 4'd0);
        check_eq("pf_second", 32'(mem_addr), 32'h0210);
        step(2'b00, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0);
        check_eq("pf_done", 32'(cmd), 32'd0);

        // Asynchronous reset mid-operation.
        step(2'b01, 16'h0700, 16'h0000, 1'b0, 4'd0, 4'd0);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        idle_inputs();
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // Fill all fifteen MSHRs, then free one.
        for (int k = 1; k < NM; k++) begin
            step(2'b01, 16'(16'h2000 + k * 16'h0100), 16'h0000, 1'b0, 4'(k), 4'd0);
        end
        step(2'b01, 16'h3000, 16'h0000, 1'b0, 4'd0, 4'd0);
        check_eq("full_set", 32'(full), 32'd1);
        check_eq("full_cmd", 32'(cmd), 32'd0);
        step(2'b01, 16'h3000, 16'h0000, 1'b0, 4'd0, 4'd1);
        step(2'b01, 16'h3000, 16'h0000, 1'b0, 4'd1, 4'd0);
        check_eq("full_clr", 32'(full), 32'd0);
        check_eq("full_resume", 32'(mem_addr), 32'h3000);

        // Random traffic with the bench acting as memory.
        for (int c = 0; c < 4000; c++) begin
            a0 = rand_addr();
            a1 = ($urandom_range(0, 3) == 0) ? (a0 ^ 16'($urandom_range(0, 7))) : rand_addr();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: dt = pick_tag(1'b1);
                4:          dt = 4'($urandom_range(1, NM - 1));
                default:    dt = 4'd0;
            endcase
            case ($urandom_range(0, 3))
                0, 1:    tt = pick_tag(1'b0);
                2:       tt = (dt != 0 && mv[dt]) ? dt : pick_tag(1'b0);
                default: tt = 4'd0;
            endcase
            step(2'($urandom_range(0, 3)), a0, a1, $urandom_range(0, 39) == 0, tt, dt);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache_nb_ctrl.md
Name: icache_nb_ctrl

Overview:
- Parametrised, non-blocking, direct-mapped instruction-cache controller with N read ports, a tag-indexed miss table (MSHR), and a sequential next-line prefetcher of configurable depth.
- Sits between fetch and instruction memory.
- Owns the tag/valid arrays and drives the index and write-enable signals of the external data array (icache_mem).
- Adds to the previous generation: flush with squash of in-flight misses, miss merging across ports, MSHR-full backpressure, and prefetch skip of already-cached or already-pending lines.

Parameters:
- N_PORTS, 2, number of fetch read ports
- ADDR_BITS, 16, significant address bits; line = 8 bytes, offset = [2:0]
- NUM_SETS, 32, lines (power of 2); IDX_W = log2(NUM_SETS); TAG_W = ADDR_BITS-IDX_W-3
- MEM_TAG_BITS, 4, memory transaction tag width; tag 0 means "none"
- PREFETCH_DEPTH, 2, lines prefetched after each accepted demand miss; 0 disables prefetch

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- proc2Icache_en  in  N_PORTS  per-port fetch request
- proc2Icache_addr  in  N_PORTS x ADDR_BITS  per-port fetch byte address
- flush  in  1  invalidate cache and squash in-flight misses
- Imem2proc_transaction_tag  in  MEM_TAG_BITS  nonzero = current request accepted with this tag
- Imem2proc_data_tag  in  MEM_TAG_BITS  nonzero = line for this tag is on the memory data bus
- proc2Imem_command  out  2  MEM_COMMAND (MEM_NONE / MEM_LOAD)
- proc2Imem_addr  out  ADDR_BITS  line-aligned request address
- Icache_valid_out  out  N_PORTS  per-port hit
- rd_idx  out  N_PORTS x IDX_W  data-array read index = addr[IDX_W+2:3]
- wr_idx  out  IDX_W  data-array write index
- data_write_enable  out  1  data array captures memory data at wr_idx
- mshr_full  out  1  all 2^MEM_TAG_BITS-1 MSHR entries valid
- miss_count  out  32  saturating count of demand-miss issues

Behaviour:
- Reset (async, reset_n=0):
  - valid array, MSHR valid bits, squash bits, prefetch count and miss_count clear.
  - Resulting outputs: command MEM_NONE, Icache_valid_out 0, data_write_enable 0, mshr_full 0.
- Hit: Icache_valid_out[i] = en[i] & valid[idx] & (tag_array[idx]==addr tag). Combinational, zero latency.
- Miss: en & !hit.
  - Pending if any valid MSHR holds the same line address (merged; no new request).
  - Demand candidate = lowest-numbered port that misses and is not pending.
- Request arbitration each cycle, demand over prefetch:
  - proc2Imem_command = MEM_LOAD iff (demand candidate or prefetch issuable) & !mshr_full & !flush.
  - Otherwise MEM_NONE, with proc2Imem_addr = 0.
- Accept: command==MEM_LOAD & transaction_tag!=0.
  - MSHR[tag] <= {line addr, valid=1, squash=0}.
  - Tag 0 response means not accepted: the same request is re-presented next cycle.
- Prefetch state (pf_addr, pf_cnt):
  - Accepted demand at line L: pf_addr <= L+8, pf_cnt <= PREFETCH_DEPTH; this also restarts an active prefetch.
  - pf_cnt>0 and pf_addr line cached or pending: skip, i.e. no request, pf_addr += 8, pf_cnt -= 1 that cycle.
  - Accepted prefetch: pf_addr += 8, pf_cnt -= 1.
  - Address arithmetic wraps modulo 2^ADDR_BITS.
- Response: data_tag!=0 & MSHR[data_tag].valid.
  - Entry clears.
  - If not squashed: data_write_enable=1 and wr_idx=entry index (combinational, same cycle); tag_array/valid updated at the next edge.
  - Squashed or invalid-tag responses: data_write_enable=0, otherwise ignored.
- Simultaneous response and accept with the same tag: the entry is cleared, then reallocated (allocation wins).
- Read and write to the same index in one cycle: read reflects the old state; the hit appears the next cycle.
- Flush (sampled at edge): all valid bits clear, all valid MSHRs set squash, pf_cnt <= 0. No request issues in the flush cycle.
- miss_count increments on each accepted demand and saturates at 2^32-1; prefetches are not counted.

Test Plan:
- Reset, then en[0]=1, addr=0x0100 → valid_out=00; MEM_LOAD addr 0x0100; tag=3 accepted; data_tag=3 three cycles later → write_en=1, wr_idx=0; next cycle valid_out[0]=1; miss_count=1.
- After a demand accept at 0x0200 with DEPTH=2 → next two accepted requests are 0x0208 and 0x0210; then MEM_NONE.
- Both ports miss on 0x0300/0x0304 (same line) → exactly one request, both ports hit after fill; ports on 0x0300/0x0400 → 0x0300 issued first, 0x0400 next free cycle ahead of prefetch.
- Fill 0x0208 first, then demand 0x0200 → prefetch skips 0x0208 and issues 0x0210.
- Issue 0x0500 with tag 5, flush, then data_tag=5 → write_en=0; previously valid line misses; MSHR entry freed.
- Hold transaction_tag nonzero until 15 MSHRs are valid → mshr_full=1 and command MEM_NONE; one response returns → mshr_full=0 and issue resumes. Assert reset_n mid-operation → outputs clear immediately.
